// File: rtl/pipe_latch.sv
// pipe_latch: generic valid/ready pipeline latch with a two-entry skid buffer
// Carries a control and a data bundle between two pipeline stages.
// Optional statistics counters are enabled by defining PIPE_LATCH_STATS_EN.
// Ports:
//   clk        rising-edge pipeline clock
//   reset      asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream presents an entry
//   in_ready   latch can accept (registered)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  downstream entry valid
//   out_ready  downstream consumes the entry
//   out_ctrl   control to next stage, zero (NOP) when out_valid=0
//   out_data   data to next stage, don't-care when out_valid=0
//   stall_cnt  saturating count of cycles out_valid=1 and out_ready=0 (stats only)
//   bubble_cnt saturating count of cycles out_valid=0 (stats only)
module pipe_latch #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
`ifdef PIPE_LATCH_STATS_EN
, parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_LATCH_STATS_EN
, output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} stateT;
  stateT state, stateNext;
  logic inReadyQ, mainValid, inXfer, outXfer;
  logic loadMain, loadSkid, moveSkid;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainData, skidData;
  assign mainValid = state != EMPTY;
  assign inXfer = in_valid & inReadyQ;
  assign outXfer = mainValid & out_ready;
  assign in_ready = inReadyQ;
  assign out_valid = mainValid;
  // A bubble carries an all-zero control bundle so it never commits state.
  assign out_ctrl = mainValid ? mainCtrl : '0;
  assign out_data = mainData;
  always_comb begin
    loadMain = inXfer & !flush & (state == EMPTY | (state == ONE & outXfer));
    loadSkid = inXfer & !flush & state == ONE & !outXfer;
    moveSkid = outXfer & !flush & state == TWO;
    stateNext = flush ? EMPTY :
                state == EMPTY ? (inXfer ? ONE : EMPTY) :
                state == ONE ? (inXfer & !outXfer ? TWO : !inXfer & outXfer ? EMPTY : ONE) :
                (outXfer ? ONE : TWO);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      inReadyQ <= 1'b1;
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
    end else begin
      state <= stateNext;
      // Registered ready: deasserted exactly while both slots are full.
      inReadyQ <= stateNext != TWO;
      if (loadMain) begin
        mainCtrl <= in_ctrl;
        mainData <= in_data;
      end else if (moveSkid) begin
        mainCtrl <= skidCtrl;
        mainData <= skidData;
      end
      if (loadSkid) begin
        skidCtrl <= in_ctrl;
        skidData <= in_data;
      end else if (moveSkid) begin
        skidCtrl <= '0;
        skidData <= '0;
      end
    end
  end
`ifdef PIPE_LATCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (mainValid & !out_ready & stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (!mainValid & bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_latch.sv
// tb_pipe_latch: directed self-checking bench for pipe_latch
module tb_pipe_latch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic [7:0] inCtrl = '0;
  logic [63:0] inData = '0;
  logic inReady, outValid;
  logic [7:0] outCtrl;
  logic [63:0] outData;
  int checks = 0;
  int errors = 0;
`ifdef PIPE_LATCH_STATS_EN
  logic [15:0] stallCnt, bubbleCnt;
  logic [1:0] stallSat, bubbleSat;
  logic inReady2, outValid2;
  logic [7:0] outCtrl2;
  logic [63:0] outData2;
`endif
  always #5 clk = ~clk;
  pipe_latch dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData)
`ifdef PIPE_LATCH_STATS_EN
  , .stall_cnt(stallCnt), .bubble_cnt(bubbleCnt)
`endif
  );
`ifdef PIPE_LATCH_STATS_EN
  pipe_latch #(.STAT_W(2)) dutSat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady2), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValid2), .out_ready(outReady), .out_ctrl(outCtrl2), .out_data(outData2),
    .stall_cnt(stallSat), .bubble_cnt(bubbleSat)
  );
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask
  task automatic send(input logic [7:0] c, input logic [63:0] d);
    inValid = 1'b1;
    inCtrl = c;
    inData = d;
    tick();
  endtask
  initial begin
    #1 reset = 1'b0;
    tick();
    tick();
    check("rst_out_valid", outValid, 0);
    check("rst_out_ctrl", outCtrl, 0);
    check("rst_out_data", outData, 0);
    check("rst_in_ready", inReady, 1);
    reset = 1'b1;
    outReady = 1'b1;
    send(8'h5A, 64'h1234);
    check("single_valid", outValid, 1);
    check("single_ctrl", outCtrl, 8'h5A);
    check("single_data", outData, 64'h1234);
    inValid = 1'b0;
    tick();
    check("single_drain_valid", outValid, 0);
    check("single_drain_ctrl", outCtrl, 0);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 64'(i));
      check("stream_valid", outValid, 1);
      check("stream_data", outData, 64'(i));
      check("stream_in_ready", inReady, 1);
    end
    inValid = 1'b0;
    tick();
    check("stream_end_valid", outValid, 0);
    outReady = 1'b0;
    send(8'h0A, 64'hA);
    check("skid_a_data", outData, 64'hA);
    check("skid_a_ready", inReady, 1);
    send(8'h0B, 64'hB);
    check("skid_full_ready", inReady, 0);
    check("skid_full_data", outData, 64'hA);
    inValid = 1'b0;
    tick();
    check("skid_hold_data", outData, 64'hA);
    check("skid_hold_ready", inReady, 0);
    outReady = 1'b1;
    tick();
    check("skid_b_valid", outValid, 1);
    check("skid_b_data", outData, 64'hB);
    check("skid_b_ctrl", outCtrl, 8'h0B);
    check("skid_b_ready", inReady, 1);
    tick();
    check("skid_drain_valid", outValid, 0);
    outReady = 1'b0;
    send(8'h0D, 64'hD);
    send(8'h0E, 64'hE);
    check("flush_pre_ready", inReady, 0);
    inCtrl = 8'h0C;
    inData = 64'hC;
    flush = 1'b1;
    tick();
    check("flush_valid", outValid, 0);
    check("flush_ctrl", outCtrl, 0);
    check("flush_ready", inReady, 1);
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    tick();
    check("flush_no_c", outValid, 0);
    tick();
    check("flush_no_c2", outValid, 0);
    outReady = 1'b0;
    send(8'h33, 64'hF);
    check("areset_pre_valid", outValid, 1);
    inValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("areset_valid", outValid, 0);
    check("areset_ctrl", outCtrl, 0);
    check("areset_ready", inReady, 1);
    tick();
    reset = 1'b1;
    outReady = 1'b1;
    tick();
    check("areset_post_valid", outValid, 0);
    tick();
    check("areset_post_valid2", outValid, 0);
`ifdef PIPE_LATCH_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    outReady = 1'b0;
    send(8'h11, 64'h11);
    inValid = 1'b0;
    tick();
    tick();
    tick();
    check("stall_cnt_3", stallCnt, 3);
    check("stall_sat_3", stallSat, 3);
    tick();
    tick();
    check("stall_cnt_5", stallCnt, 5);
    check("stall_sat_hold", stallSat, 3);
    outReady = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("bubble_ge_4", 64'(bubbleCnt >= 16'd4), 1);
    check("stall_after_idle", stallCnt, 5);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
